csr_unit: RTL and testbench
===========================

# csr_unit

Parameterised control/status register file for the multi-cycle core, replacing the single-register SATP file. It holds the supervisor/machine CSRs the datapath and MMU need and executes the atomic CSR read-modify-write operations (RW/RS/RC) in one cycle. It runs free-running cycle and retired-instruction counters and captures trap state. Illegal accesses are flagged to the control FSM.

## Interface
- DATA_WIDTH, 32, width of every CSR and data port
- ADDR_WIDTH, 12, CSR address width
- HART_ID, 0, constant value returned by mhartid
- clk_i  in  1  clock
- rst_i  in  1  reset; **synchronous, active-high**
- op_i  in  2  CSR op: 00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits)
- addr_i  in  ADDR_WIDTH  CSR address
- wdata_i  in  DATA_WIDTH  source operand (rs1 value or zimm, zero-extended by the datapath)
- rdata_o  out  DATA_WIDTH  old CSR value (combinational)
- illegal_o  out  1  access illegal this cycle (combinational)
- instret_i  in  1  one instruction retired this cycle
- trap_i  in  1  trap taken this cycle
- trap_pc_i  in  DATA_WIDTH  PC of the trapping instruction
- trap_cause_i  in  DATA_WIDTH  cause code
- satp_o, mtvec_o, mepc_o  out  DATA_WIDTH  live register values for the MMU and PC logic

## Operation
- Map: satp 0x180, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342 (all RW).
- Counters: mcycle 0xB00 and minstret 0xB02 (RW).
- Read-only: mhartid 0xF14 returns HART_ID.
- Any other address is unmapped.
- New value for a write:
  - RW: wdata_i
  - RS: old | wdata_i
  - RC: old & ~wdata_i
- Write attempt:
  - op RW always counts as a write attempt.
  - op RS or RC counts as a write attempt only when wdata_i != 0.
  - RS/RC with wdata_i == 0 is a pure read and has no side effect.
- illegal_o = op_i != 00 and (address unmapped, or write attempt to an address with addr_i[11:10] == 2'b11).
  - Illegal accesses write nothing.
  - rdata_o is 0 when the address is unmapped.
  - A read of mhartid with op RW is illegal.
- WARL fields:
  - mtvec[1:0] and mepc[1:0] always read 0; written low bits are dropped.
  - All other registers store full width.
- mcycle:
  - Increments by 1 every cycle out of reset.
  - Wraps from all-ones to 0.
- minstret:
  - Increments by 1 on instret_i.
  - Wraps from all-ones to 0.
- Trap (trap_i = 1): mepc <= {trap_pc_i[DATA_WIDTH-1:2], 2'b00}; mcause <= trap_cause_i.
- Priorities within one cycle:
  - Trap over CSR write to mepc or mcause: the trap value wins and the CSR write to that register is dropped. CSR writes to other registers proceed.
  - An explicit CSR write to mcycle or minstret overrides that cycle's increment. The written value is stored as-is, not written value + 1.
- op_i == 00: illegal_o = 0, no write. rdata_o still shows the addressed register (0 if unmapped).

## Timing
- Reset (rst_i high at a clock edge): every register is 0, including mcycle and minstret.
  - Outputs during reset: satp_o, mtvec_o, mepc_o are 0.
  - rdata_o is 0 for all mapped addresses except mhartid, which reads HART_ID.
- Reset dominates trap, CSR write and counter increments on the same edge.
- Reset mid-operation discards any in-flight write.
- rdata_o and illegal_o are combinational from op_i, addr_i, wdata_i and current state, with zero latency.
- Writes, trap capture and counter increments commit at the next rising edge.
  - The new value is visible on rdata_o and the *_o ports from the following cycle.
- The cycle after reset is released, mcycle reads 0. It reads 1 one cycle later.
- No handshake: the control FSM asserts op_i for exactly one cycle per CSR instruction.
  - Holding op_i for N cycles performs N operations. RS/RC are idempotent; RW repeats the same write.

## Test plan
- Reset, then RW satp with 0xDEADBEEF -> rdata_o = 0 that cycle; satp_o = 0xDEADBEEF next cycle.
- mscratch = 0xF0F0_00FF; RS with 0x0000_FF00 then RC with 0x0000_00F0 -> rdata_o 0xF0F000FF then 0xF0F0FFFF; final value 0xF0F0FF0F.
- RW mtvec with 0x8000_0003 -> mtvec_o = 0x8000_0000.
- Same cycle: trap_i with pc 0x1006 and cause 0x2, plus RW mepc 0x5555 -> mepc_o = 0x1004, mcause = 2.
- RW mhartid -> illegal_o = 1, no state change.
- RS mhartid with wdata 0 -> illegal_o = 0, rdata_o = HART_ID.
- RW to address 0x7C0 -> illegal_o = 1, rdata_o = 0.
- RW mcycle with 0xFFFF_FFFF, then idle 2 cycles -> reads 0xFFFFFFFF, 0x0, 0x1 (override then wrap).
- instret_i pulsed 3 times -> minstret = 3.
- Assert rst_i mid-count -> all registers 0 next cycle.

Source files
------------

// File: rtl/csr_unit.sv
// Machine/supervisor CSR file: single-cycle RW/RS/RC access, free-running
// cycle/instret counters, trap capture, and illegal-access detection.
module csr_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned HART_ID    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            op_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  illegal_o,
  input  logic                  instret_i,
  input  logic                  trap_i,
  input  logic [DATA_WIDTH-1:0] trap_pc_i,
  input  logic [DATA_WIDTH-1:0] trap_cause_i,
  output logic [DATA_WIDTH-1:0] satp_o,
  output logic [DATA_WIDTH-1:0] mtvec_o,
  output logic [DATA_WIDTH-1:0] mepc_o
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_SATP,
    SEL_MTVEC,
    SEL_MSCRATCH,
    SEL_MEPC,
    SEL_MCAUSE,
    SEL_MCYCLE,
    SEL_MINSTRET,
    SEL_MHARTID
  } sel_e;

  localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] WARL_MASK = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] HART_VAL  = DATA_WIDTH'(HART_ID);

  logic [DATA_WIDTH-1:0] satp_q;
  logic [DATA_WIDTH-1:0] mtvec_q;
  logic [DATA_WIDTH-1:0] mscratch_q;
  logic [DATA_WIDTH-1:0] mepc_q;
  logic [DATA_WIDTH-1:0] mcause_q;
  logic [DATA_WIDTH-1:0] mcycle_q;
  logic [DATA_WIDTH-1:0] minstret_q;

  op_e                   op;
  sel_e                  sel;
  logic [DATA_WIDTH-1:0] old_val;
  logic [DATA_WIDTH-1:0] new_val;
  logic                  write_attempt;
  logic                  read_only;
  logic                  do_write;

  assign op        = op_e'(op_i);
  assign read_only = (addr_i[ADDR_WIDTH-1 -: 2] == 2'b11);

  always_comb begin
    sel = SEL_NONE;
    case (addr_i)
      ADDR_WIDTH'(12'h180): sel = SEL_SATP;
      ADDR_WIDTH'(12'h305): sel = SEL_MTVEC;
      ADDR_WIDTH'(12'h340): sel = SEL_MSCRATCH;
      ADDR_WIDTH'(12'h341): sel = SEL_MEPC;
      ADDR_WIDTH'(12'h342): sel = SEL_MCAUSE;
      ADDR_WIDTH'(12'hB00): sel = SEL_MCYCLE;
      ADDR_WIDTH'(12'hB02): sel = SEL_MINSTRET;
      ADDR_WIDTH'(12'hF14): sel = SEL_MHARTID;
      default:              sel = SEL_NONE;
    endcase
  end

  always_comb begin
    old_val = '0;
    case (sel)
      SEL_SATP:     old_val = satp_q;
      SEL_MTVEC:    old_val = mtvec_q;
      SEL_MSCRATCH: old_val = mscratch_q;
      SEL_MEPC:     old_val = mepc_q;
      SEL_MCAUSE:   old_val = mcause_q;
      SEL_MCYCLE:   old_val = mcycle_q;
      SEL_MINSTRET: old_val = minstret_q;
      SEL_MHARTID:  old_val = HART_VAL;
      default:      old_val = '0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it never trips the read-only check.
  always_comb begin
    write_attempt = (op == OP_RW) || ((op != OP_NONE) && (wdata_i != '0));
    illegal_o     = (op != OP_NONE) && ((sel == SEL_NONE) || (write_attempt && read_only));
    do_write      = (op != OP_NONE) && write_attempt && !illegal_o;
    new_val       = old_val;
    case (op)
      OP_RW:   new_val = wdata_i;
      OP_RS:   new_val = old_val | wdata_i;
      OP_RC:   new_val = old_val & ~wdata_i;
      default: new_val = old_val;
    endcase
  end

  assign rdata_o = old_val;
  assign satp_o  = satp_q;
  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      satp_q     <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q <= mcycle_q + ONE;
      if (instret_i) begin
        minstret_q <= minstret_q + ONE;
      end
      // Later assignments win: an explicit write overrides the counter
      // increment, and trap capture overrides a write to mepc/mcause.
      if (do_write) begin
        case (sel)
          SEL_SATP:     satp_q     <= new_val;
          SEL_MTVEC:    mtvec_q    <= new_val & WARL_MASK;
          SEL_MSCRATCH: mscratch_q <= new_val;
          SEL_MEPC:     mepc_q     <= new_val & WARL_MASK;
          SEL_MCAUSE:   mcause_q   <= new_val;
          SEL_MCYCLE:   mcycle_q   <= new_val;
          SEL_MINSTRET: minstret_q <= new_val;
          default:      ;
        endcase
      end
      if (trap_i) begin
        mepc_q   <= trap_pc_i & WARL_MASK;
        mcause_q <= trap_cause_i;
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against an address-map model.
module tb_csr_unit;

  localparam int unsigned HART = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        illegal;
  logic        instret;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] satp;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  always #5 clk = ~clk;

  csr_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(12),
    .HART_ID   (HART)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .op_i        (op),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .illegal_o   (illegal),
    .instret_i   (instret),
    .trap_i      (trap),
    .trap_pc_i   (trap_pc),
    .trap_cause_i(trap_cause),
    .satp_o      (satp),
    .mtvec_o     (mtvec),
    .mepc_o      (mepc)
  );

  int checks = 0;
  int errors = 0;

  // Model: one word per CSR address; unmapped entries are never read.
  logic [31:0] mreg [4096];
  logic [31:0] got_rdata;
  logic        got_ill;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [17];

  logic [11:0] addr_pool [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit mapped(input logic [11:0] a);
    return a inside {12'h180, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'hB00, 12'hB02, 12'hF14};
  endfunction

  function automatic logic [31:0] mread(input logic [11:0] a);
    if (a == 12'hF14) return 32'(HART);
    if (mapped(a)) return mreg[a];
    return 32'h0;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 4096; i++) mreg[i] = 32'h0;
  endtask

  // Drive one cycle, compare outputs mid-cycle, then advance the model.
  task automatic step(input logic r, input logic [1:0] o, input logic [11:0] a,
                      input logic [31:0] wd, input logic ir, input logic tr,
                      input logic [31:0] pc, input logic [31:0] cause);
    logic [31:0] old;
    logic [31:0] nv;
    logic [31:0] cyc;
    logic [31:0] ins;
    bit          wa;
    bit          ill;
    rst = r; op = o; addr = a; wdata = wd; instret = ir; trap = tr;
    trap_pc = pc; trap_cause = cause;
    @(negedge clk);
    old = mread(a);
    wa  = (o == 2'd1) || (o != 2'd0 && wd != 32'h0);
    ill = (o != 2'd0) && (!mapped(a) || (wa && a >= 12'hC00));
    got_rdata = rdata;
    got_ill   = illegal;
    check("rdata", rdata, old);
    check("illegal", 32'(illegal), 32'(ill));
    check("satp_o", satp, mreg[12'h180]);
    check("mtvec_o", mtvec, mreg[12'h305]);
    check("mepc_o", mepc, mreg[12'h341]);
    if (r) begin
      mreset();
    end else begin
      cyc = mreg[12'hB00] + 32'd1;
      ins = ir ? mreg[12'hB02] + 32'd1 : mreg[12'hB02];
      mreg[12'hB00] = cyc;
      mreg[12'hB02] = ins;
      if (wa && !ill) begin
        case (o)
          2'd1:    nv = wd;
          2'd2:    nv = old | wd;
          default: nv = old & ~wd;
        endcase
        if (a == 12'h305 || a == 12'h341) nv[1:0] = 2'b00;
        mreg[a] = nv;
      end
      if (tr) begin
        mreg[12'h341] = {pc[31:2], 2'b00};
        mreg[12'h342] = cause;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    step(1'b0, 2'd0, a, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check(name, got_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] o, input logic [11:0] a, input logic [31:0] wd);
    step(1'b0, o, a, wd, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 2'd0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; op = 2'd0; addr = 12'h0; wdata = 32'h0;
    instret = 1'b0; trap = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    mreset();

    // Reset-held reads, then counter start after release.
    step(1'b1, 2'd0, 12'hF14, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("reset_hartid", got_rdata, 32'(HART));
    step(1'b1, 2'd0, 12'h180, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("reset_satp", got_rdata, 32'h0);
    rd("mcycle_first", 12'hB00, 32'h0);
    rd("mcycle_second", 12'hB00, 32'h1);

    vecs[0]  = '{2'd1, 12'h180, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{2'd0, 12'h180, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{2'd1, 12'h340, 32'hF0F000FF, 32'h0,        1'b0};
    vecs[3]  = '{2'd2, 12'h340, 32'h0000FF00, 32'hF0F000FF, 1'b0};
    vecs[4]  = '{2'd3, 12'h340, 32'h000000F0, 32'hF0F0FFFF, 1'b0};
    vecs[5]  = '{2'd0, 12'h340, 32'h0,        32'hF0F0FF0F, 1'b0};
    vecs[6]  = '{2'd1, 12'h305, 32'h80000003, 32'h0,        1'b0};
    vecs[7]  = '{2'd0, 12'h305, 32'h0,        32'h80000000, 1'b0};
    vecs[8]  = '{2'd1, 12'hF14, 32'h00001234, 32'(HART),    1'b1};
    vecs[9]  = '{2'd2, 12'hF14, 32'h0,        32'(HART),    1'b0};
    vecs[10] = '{2'd3, 12'hF14, 32'h00000005, 32'(HART),    1'b1};
    vecs[11] = '{2'd1, 12'h7C0, 32'h0000AAAA, 32'h0,        1'b1};
    vecs[12] = '{2'd0, 12'h7C0, 32'h0,        32'h0,        1'b0};
    vecs[13] = '{2'd2, 12'h305, 32'h00000003, 32'h80000000, 1'b0};
    vecs[14] = '{2'd0, 12'h305, 32'h0,        32'h80000000, 1'b0};
    vecs[15] = '{2'd3, 12'h180, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[16] = '{2'd2, 12'hC00, 32'h0,        32'h0,        1'b1};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      wr(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_illegal", i), 32'(got_ill), 32'(vecs[i].exp_ill));
    end
    check("satp_port", satp, 32'hDEADBEEF);
    check("mtvec_port", mtvec, 32'h80000000);

    // Trap beats a same-cycle write to mepc; writes elsewhere still land.
    step(1'b0, 2'd1, 12'h341, 32'h00005555, 1'b0, 1'b1, 32'h00001006, 32'h2);
    check("trap_mepc_port", mepc, 32'h00001004);
    rd("trap_mepc", 12'h341, 32'h00001004);
    rd("trap_mcause", 12'h342, 32'h2);
    step(1'b0, 2'd1, 12'h340, 32'h00000077, 1'b0, 1'b1, 32'h0000200B, 32'h3);
    rd("trap_side_write", 12'h340, 32'h00000077);
    rd("trap2_mepc", 12'h341, 32'h00002008);

    // Counter override then wrap.
    wr(2'd1, 12'hB00, 32'hFFFFFFFF);
    rd("mcycle_written", 12'hB00, 32'hFFFFFFFF);
    rd("mcycle_wrap", 12'hB00, 32'h0);
    rd("mcycle_after_wrap", 12'hB00, 32'h1);

    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    rd("minstret_three", 12'hB02, 32'h3);
    step(1'b0, 2'd1, 12'hB02, 32'h10, 1'b1, 1'b0, 32'h0, 32'h0);
    rd("minstret_override", 12'hB02, 32'h10);
    wr(2'd1, 12'hB02, 32'hFFFFFFFF);
    step(1'b0, 2'd0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    rd("minstret_wrap", 12'hB02, 32'h0);

    // Reset mid-operation discards the in-flight write, trap and increments.
    wr(2'd1, 12'h180, 32'h00001234);
    wr(2'd1, 12'h305, 32'h00000100);
    step(1'b1, 2'd1, 12'h340, 32'h99, 1'b1, 1'b1, 32'h40, 32'h5);
    rd("rst_mcycle", 12'hB00, 32'h0);
    rd("rst_minstret", 12'hB02, 32'h0);
    rd("rst_satp", 12'h180, 32'h0);
    rd("rst_mscratch", 12'h340, 32'h0);
    rd("rst_mepc", 12'h341, 32'h0);
    rd("rst_mcause", 12'h342, 32'h0);
    rd("rst_mtvec", 12'h305, 32'h0);

    addr_pool = '{12'h180, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                  12'hB02, 12'hF14, 12'h7C0, 12'hC00, 12'hF15, 12'h000};
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] wd;
      case ($urandom_range(0, 5))
        0:       wd = 32'h0;
        1:       wd = 32'hFFFFFFFE;
        default: wd = $urandom;
      endcase
      step(($urandom_range(0, 49) == 0),
           2'($urandom_range(0, 3)),
           addr_pool[$urandom_range(0, 11)],
           wd,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0),
           $urandom,
           $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
